modn_updown_counter: RTL and testbench

//  Parametrised modulo-N counter for the 1 Hz board timebase. Supports up, down,
//  one-shot and ping-pong modes, parallel load, enable and a terminal-count pulse.

---
 rtl/modn_updown_counter_pkg.sv | 14 +
 rtl/modn_updown_counter_if.sv | 44 ++++
 rtl/modn_updown_counter.sv | 144 ++++++++++++++
 tb/tb_modn_updown_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/modn_updown_counter_pkg.sv
// Package: counter_pkg
// Shared mode encodings and the mode type used by the modulo-N counter,
// its bus interface and anything else that needs to drive MODE.
// Optional feature macro used by the counter files: COUNTER_CASCADE_EN.
package counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP       = 2'b00;
  localparam mode_t MODE_DN       = 2'b01;
  localparam mode_t MODE_ONESHOT  = 2'b10;
  localparam mode_t MODE_PINGPONG = 2'b11;

endpackage

// File: rtl/modn_updown_counter_if.sv
// Interface: modn_updown_counter_if
// Control/status bundle of the modulo-N counter.
//   master : drives EN, MODE, LOAD, LOAD_VAL (and CI); observes DOUT, TC, DONE (and CO)
//   slave  : the counter itself
// Macro COUNTER_CASCADE_EN adds the carry-in CI and carry-out CO signals.
interface modn_updown_counter_if #(
  parameter int WIDTH = 4
);
  import counter_pkg::*;

  logic             EN;
  mode_t            MODE;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] DOUT;
  logic             TC;
  logic             DONE;

`ifdef COUNTER_CASCADE_EN
  logic             CI;
  logic             CO;

  modport master (
    output EN, MODE, LOAD, LOAD_VAL, CI,
    input  DOUT, TC, DONE, CO
  );

  modport slave (
    input  EN, MODE, LOAD, LOAD_VAL, CI,
    output DOUT, TC, DONE, CO
  );
`else
  modport master (
    output EN, MODE, LOAD, LOAD_VAL,
    input  DOUT, TC, DONE
  );

  modport slave (
    input  EN, MODE, LOAD, LOAD_VAL,
    output DOUT, TC, DONE
  );
`endif

endinterface

// File: rtl/modn_updown_counter.sv
// Module: modn_updown_counter
// Modulo-N counter for the 1 Hz timebase: up-wrap, down-wrap, up-one-shot and
// ping-pong modes, synchronous parallel load, enable, registered terminal-count
// pulse (TC) and registered one-shot finished flag (DONE).
// Ports:
//   CLK_1Hz : count clock
//   RST     : asynchronous, active-low reset
//   bus     : modn_updown_counter_if.slave (EN, MODE, LOAD, LOAD_VAL -> DOUT, TC, DONE)
// Parameters: WIDTH (count width), MODULUS (count range 0..MODULUS-1).
// Macro COUNTER_CASCADE_EN: adds CI/CO on the bus; counting needs EN && CI and CO
// flags (combinationally) that the next enabled edge wraps/bounces/finishes.
// Without the macro CI is treated as 1.
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                 CLK_1Hz,
  input  logic                 RST,
  modn_updown_counter_if.slave bus
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("modn_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] dout;
  logic             tc;
  logic             done;
  logic             dir_up;
  logic             ci;
  logic             count_en;

`ifdef COUNTER_CASCADE_EN
  logic at_point;

  assign ci = bus.CI;

  // Count value at which the next enabled edge wraps, bounces or finishes.
  always_comb begin
    at_point = 1'b0;
    case (bus.MODE)
      MODE_UP:       at_point = (dout == MAX);
      MODE_DN:       at_point = (dout == ZERO);
      MODE_ONESHOT:  at_point = !done && (dout >= MAX - ONE);
      MODE_PINGPONG: at_point = dir_up ? (dout == MAX) : (dout == ZERO);
      default:       at_point = 1'b0;
    endcase
  end

  assign bus.CO = ci & bus.EN & at_point;
`else
  assign ci = 1'b1;
`endif

  assign count_en = bus.EN & ci;

  always_ff @(posedge CLK_1Hz or negedge RST) begin
    if (!RST) begin
      dout   <= '0;
      tc     <= 1'b0;
      done   <= 1'b0;
      dir_up <= 1'b1;
    end else if (bus.LOAD) begin
      dout   <= (bus.LOAD_VAL > MAX) ? MAX : bus.LOAD_VAL;
      tc     <= 1'b0;
      done   <= 1'b0;
      dir_up <= 1'b1;
    end else if (count_en) begin
      case (bus.MODE)
        MODE_UP: begin
          done <= 1'b0;
          if (dout >= MAX) begin
            dout <= '0;
            tc   <= 1'b1;
          end else begin
            dout <= dout + ONE;
            tc   <= 1'b0;
          end
        end
        MODE_DN: begin
          done <= 1'b0;
          if (dout == ZERO) begin
            dout <= MAX;
            tc   <= 1'b1;
          end else begin
            dout <= dout - ONE;
            tc   <= 1'b0;
          end
        end
        MODE_ONESHOT: begin
          if (done) begin
            tc <= 1'b0;
          end else if (dout >= MAX - ONE) begin
            // Also covers a count already sitting at MAX (e.g. after a load):
            // that edge is treated as the finish.
            dout <= MAX;
            done <= 1'b1;
            tc   <= 1'b1;
          end else begin
            dout <= dout + ONE;
            tc   <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
          if (dir_up) begin
            if (dout >= MAX) begin
              dout   <= MAX - ONE;
              dir_up <= 1'b0;
              tc     <= 1'b1;
            end else begin
              dout <= dout + ONE;
              tc   <= 1'b0;
            end
          end else begin
            if (dout == ZERO) begin
              dout   <= ONE;
              dir_up <= 1'b1;
              tc     <= 1'b1;
            end else begin
              dout <= dout - ONE;
              tc   <= 1'b0;
            end
          end
        end
      endcase
    end else begin
      tc <= 1'b0;
    end
  end

  assign bus.DOUT = dout;
  assign bus.TC   = tc;
  assign bus.DONE = done;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Testbench: tb_modn_updown_counter
// Vector table with a scoreboard queue for the WIDTH=4/MODULUS=10 counter, plus
// hand-written sequences for async reset, a MODULUS=2 ping-pong instance and,
// with COUNTER_CASCADE_EN defined, a two-stage 00..99 cascade.
module tb_modn_updown_counter;
  import counter_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  modn_updown_counter_if #(.WIDTH(4)) a ();
  modn_updown_counter_if #(.WIDTH(4)) b ();

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .CLK_1Hz (clk),
    .RST     (rst_n),
    .bus     (a.slave)
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(2)) dut_m2 (
    .CLK_1Hz (clk),
    .RST     (rst_n),
    .bus     (b.slave)
  );

`ifdef COUNTER_CASCADE_EN
  modn_updown_counter_if #(.WIDTH(4)) cl ();
  modn_updown_counter_if #(.WIDTH(4)) ch ();

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .CLK_1Hz (clk),
    .RST     (rst_n),
    .bus     (cl.slave)
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .CLK_1Hz (clk),
    .RST     (rst_n),
    .bus     (ch.slave)
  );

  assign ch.CI = cl.CO;
`endif

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] lv;
    logic [3:0] dout;
    logic       tc;
    logic       done;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic en, input logic [1:0] mode, input logic load,
                              input logic [3:0] lv, input logic [3:0] dout,
                              input logic tc, input logic done);
    vec_t v;
    v.en = en; v.mode = mode; v.load = load; v.lv = lv;
    v.dout = dout; v.tc = tc; v.done = done;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one vector, record its expectation, let one edge pass and compare.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    a.EN = v.en; a.MODE = v.mode; a.LOAD = v.load; a.LOAD_VAL = v.lv;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " dout"}, 32'(a.DOUT), 32'(e.dout));
    chk({tag, " tc"},   32'(a.TC),   32'(e.tc));
    chk({tag, " done"}, 32'(a.DONE), 32'(e.done));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [3:0] m2_exp_d[6] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
    logic       m2_exp_t[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // 1: up-wrap from reset
    for (int i = 1; i <= 12; i++) add(1, MODE_UP, 0, 0, 4'(i % 10), i == 10, 0);
    // 2: down-wrap from 0, then hold
    add(0, MODE_UP, 1, 0, 0, 0, 0);
    add(1, MODE_DN, 0, 0, 9, 1, 0);
    add(1, MODE_DN, 0, 0, 8, 0, 0);
    add(1, MODE_DN, 0, 0, 7, 0, 0);
    for (int i = 0; i < 3; i++) add(0, MODE_DN, 0, 0, 7, 0, 0);
    // 3: one-shot, hold at MAX, clamp on load, mode change clears DONE
    add(0, MODE_UP, 1, 7, 7, 0, 0);
    add(1, MODE_ONESHOT, 0, 0, 8, 0, 0);
    add(1, MODE_ONESHOT, 0, 0, 9, 1, 1);
    for (int i = 0; i < 5; i++) add(1, MODE_ONESHOT, 0, 0, 9, 0, 1);
    add(0, MODE_ONESHOT, 0, 0, 9, 0, 1);
    add(0, MODE_ONESHOT, 1, 15, 9, 0, 0);
    add(1, MODE_UP, 0, 0, 0, 1, 0);
    add(0, MODE_UP, 1, 8, 8, 0, 0);
    add(1, MODE_ONESHOT, 0, 0, 9, 1, 1);
    add(1, MODE_DN, 0, 0, 8, 0, 0);
    // 4: ping-pong 20 edges from 0, then direction survives a mode change
    add(0, MODE_UP, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      if (i <= 9)       add(1, MODE_PINGPONG, 0, 0, 4'(i), 0, 0);
      else if (i == 10) add(1, MODE_PINGPONG, 0, 0, 8, 1, 0);
      else if (i <= 18) add(1, MODE_PINGPONG, 0, 0, 4'(18 - i), 0, 0);
      else if (i == 19) add(1, MODE_PINGPONG, 0, 0, 1, 1, 0);
      else              add(1, MODE_PINGPONG, 0, 0, 2, 0, 0);
    end
    for (int i = 3; i <= 9; i++) add(1, MODE_PINGPONG, 0, 0, 4'(i), 0, 0);
    add(1, MODE_PINGPONG, 0, 0, 8, 1, 0);
    add(1, MODE_UP, 0, 0, 9, 0, 0);
    add(1, MODE_PINGPONG, 0, 0, 8, 0, 0);
    // 5: load beats enable; walk down to 5 with dir=down before the reset
    add(1, MODE_UP, 1, 3, 3, 0, 0);
    add(0, MODE_UP, 1, 9, 9, 0, 0);
    add(1, MODE_PINGPONG, 0, 0, 8, 1, 0);
    add(1, MODE_PINGPONG, 0, 0, 7, 0, 0);
    add(1, MODE_PINGPONG, 0, 0, 6, 0, 0);
    add(1, MODE_PINGPONG, 0, 0, 5, 0, 0);

    rst_n = 1'b0;
    a.EN = 0; a.MODE = MODE_UP; a.LOAD = 0; a.LOAD_VAL = 0;
    b.EN = 0; b.MODE = MODE_UP; b.LOAD = 0; b.LOAD_VAL = 0;
`ifdef COUNTER_CASCADE_EN
    a.CI = 1; b.CI = 1;
    cl.EN = 0; cl.MODE = MODE_UP; cl.LOAD = 0; cl.LOAD_VAL = 0; cl.CI = 1;
    ch.EN = 0; ch.MODE = MODE_UP; ch.LOAD = 0; ch.LOAD_VAL = 0;
`endif
    #3;
    chk("reset dout", 32'(a.DOUT), 0);
    chk("reset tc",   32'(a.TC),   0);
    chk("reset done", 32'(a.DONE), 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset hold dout", 32'(a.DOUT), 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Async reset mid-period while DOUT=5 and dir=down
    #3 rst_n = 1'b0;
    #1;
    chk("async rst dout", 32'(a.DOUT), 0);
    chk("async rst tc",   32'(a.TC),   0);
    chk("async rst done", 32'(a.DONE), 0);
    #1 rst_n = 1'b1;
    // dir must be back to up: 0 -> 1 without a bounce pulse
    v.en = 1; v.mode = MODE_PINGPONG; v.load = 0; v.lv = 0; v.dout = 1; v.tc = 0; v.done = 0;
    step(v, "post-rst pingpong");
    a.EN = 0;

    // MODULUS=2 ping-pong
    b.EN = 1; b.MODE = MODE_PINGPONG;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("m2 edge%0d dout", i), 32'(b.DOUT), 32'(m2_exp_d[i]));
      chk($sformatf("m2 edge%0d tc", i),   32'(b.TC),   32'(m2_exp_t[i]));
    end
    b.EN = 0;

`ifdef COUNTER_CASCADE_EN
    cl.EN = 1; ch.EN = 1;
    for (int i = 1; i <= 105; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cascade%0d lo", i), 32'(cl.DOUT), 32'(i % 10));
      chk($sformatf("cascade%0d hi", i), 32'(ch.DOUT), 32'((i / 10) % 10));
      chk($sformatf("cascade%0d hi tc", i), 32'(ch.TC), 32'(i == 100));
    end
    cl.EN = 0; ch.EN = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
